ifm_skew_rf_bank: RTL and testbench

- Parametrised, double-buffered bank of skewed IFM shift register files that feeds the systolic array's row inputs.
- Lane i has depth BASE_DEPTH+i, so drained data leaves as a diagonal wavefront.
- Two banks (ping/pong) allow one tile to load while the previous one drains.
- Internal bank sequencing and valid/ready handshakes on both sides replace external demux/mux/shift-enable strobes; the active-lane count is captured per tile.

---
 rtl/ifm_skew_rf_bank.sv | 189 ++++++++++++++++++
 tb/tb_ifm_skew_rf_bank.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifm_skew_rf_bank.sv
// Double-buffered bank of skewed IFM shift register files feeding the
// systolic array row inputs. Lane i of each bank is BASE_DEPTH+i words deep,
// so a drained tile leaves as a diagonal wavefront. One bank fills while the
// other drains; valid/ready handshakes sit on both sides.
// Optional: define IFM_RF_STALL_CNT_EN to build the drain-stall counter.
module ifm_skew_rf_bank #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 16,
    parameter int BASE_DEPTH = 27,
    parameter int SIZE_W     = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic [SIZE_W-1:0]           size,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*DATA_WIDTH-1:0] data_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*DATA_WIDTH-1:0] data_out,
    output logic                        out_first,
    output logic                        out_last,
    output logic [31:0]                 stall_cnt
);

    // Drain beats per tile: the deepest lane needs LANES-1 extra beats.
    localparam int N   = BASE_DEPTH + LANES - 1;
    localparam int FCW = $clog2(BASE_DEPTH + 1);
    localparam int DCW = $clog2(N + 1);

    typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_e;

    bank_state_e         state_q [2];
    bank_state_e         state_d [2];
    logic                fill_ptr_q, fill_ptr_d;
    logic                drain_ptr_q, drain_ptr_d;
    logic [FCW-1:0]      fill_cnt_q, fill_cnt_d;
    logic [DCW-1:0]      drain_cnt_q, drain_cnt_d;
    // Only the fill bank ever needs its lane count, so one register serves
    // whichever bank is currently filling.
    logic [SIZE_W-1:0]   size_q, size_d;
    logic [SIZE_W-1:0]   size_in_eff;
    logic [SIZE_W-1:0]   size_cur;
    logic                in_fire, out_fire;
    logic [1:0]          fill_shift, drain_shift;
    logic [DATA_WIDTH-1:0] last_word [2][LANES];

    // Out-of-range sizes mean "all lanes"; beat 0 uses the live port value.
    assign size_in_eff = (size == '0 || size > SIZE_W'(LANES)) ? SIZE_W'(LANES) : size;
    assign size_cur    = (fill_cnt_q == '0) ? size_in_eff : size_q;

    // State register: bank states, pointers, beat counters, latched size.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q[0]  <= EMPTY;
            state_q[1]  <= EMPTY;
            fill_ptr_q  <= 1'b0;
            drain_ptr_q <= 1'b0;
            fill_cnt_q  <= '0;
            drain_cnt_q <= '0;
            size_q      <= '0;
        end else begin
            state_q     <= state_d;
            fill_ptr_q  <= fill_ptr_d;
            drain_ptr_q <= drain_ptr_d;
            fill_cnt_q  <= fill_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            size_q      <= size_d;
        end
    end

    // Next-state logic; fill and drain always touch different banks.
    // NOTE: every variable gets a default at the top of the block so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        fill_ptr_d  = fill_ptr_q;
        drain_ptr_d = drain_ptr_q;
        fill_cnt_d  = fill_cnt_q;
        drain_cnt_d = drain_cnt_q;
        size_d      = size_q;
        if (flush) begin
            state_d[0]  = EMPTY;
            state_d[1]  = EMPTY;
            fill_ptr_d  = 1'b0;
            drain_ptr_d = 1'b0;
            fill_cnt_d  = '0;
            drain_cnt_d = '0;
            size_d      = '0;
        end else begin
            if (in_fire) begin
                if (fill_cnt_q == '0) size_d = size_in_eff;
                if (fill_cnt_q == FCW'(BASE_DEPTH - 1)) begin
                    state_d[fill_ptr_q] = FULL;
                    fill_ptr_d          = ~fill_ptr_q;
                    fill_cnt_d          = '0;
                end else begin
                    state_d[fill_ptr_q] = FILLING;
                    fill_cnt_d          = fill_cnt_q + FCW'(1);
                end
            end
            if (out_valid) begin
                state_d[drain_ptr_q] = DRAINING;
                if (out_fire) begin
                    if (drain_cnt_q == DCW'(N - 1)) begin
                        state_d[drain_ptr_q] = EMPTY;
                        drain_ptr_d          = ~drain_ptr_q;
                        drain_cnt_d          = '0;
                    end else begin
                        drain_cnt_d = drain_cnt_q + DCW'(1);
                    end
                end
            end
        end
    end

    // Outputs and per-bank shift enables, decoded from registered state only.
    always_comb begin
        in_ready    = (state_q[fill_ptr_q] == EMPTY) || (state_q[fill_ptr_q] == FILLING);
        out_valid   = (state_q[drain_ptr_q] == FULL) || (state_q[drain_ptr_q] == DRAINING);
        in_fire     = in_valid && in_ready;
        out_fire    = out_valid && out_ready;
        out_first   = out_valid && (drain_cnt_q == '0);
        out_last    = out_valid && (drain_cnt_q == DCW'(N - 1));
        fill_shift  = '0;
        drain_shift = '0;
        fill_shift[fill_ptr_q]   = in_fire;
        drain_shift[drain_ptr_q] = out_fire;
    end

    // Skewed lane storage; draining shifts zeros in, leaving the bank clean.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            localparam int D = BASE_DEPTH + i;
            logic [DATA_WIDTH-1:0] sr [D];
            logic [DATA_WIDTH-1:0] shift_in;

            assign shift_in = (fill_shift[b] && (SIZE_W'(i) < size_cur))
                              ? data_in[i*DATA_WIDTH +: DATA_WIDTH] : '0;

            // Lane shift register: load on fill beats, zero-fill on drain beats.
            // NOTE: storage is cleared on reset because a stale word would
            // otherwise surface on the wavefront edges of the first tile.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int j = 0; j < D; j++) sr[j] <= '0;
                end else if (flush) begin
                    for (int j = 0; j < D; j++) sr[j] <= '0;
                end else if (fill_shift[b] || drain_shift[b]) begin
                    for (int j = D - 1; j > 0; j--) sr[j] <= sr[j-1];
                    sr[0] <= shift_in;
                end
            end

            assign last_word[b][i] = sr[D-1];
        end
    end

    // Drain bank's last stages drive the array rows.
    always_comb begin
        data_out = '0;
        for (int i = 0; i < LANES; i++) begin
            data_out[i*DATA_WIDTH +: DATA_WIDTH] = last_word[drain_ptr_q][i];
        end
    end

`ifdef IFM_RF_STALL_CNT_EN
    logic [31:0] stall_q;

    // Saturating count of cycles the array back-pressures a valid beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (flush) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ifm_skew_rf_bank.sv
// Directed bench for ifm_skew_rf_bank with LANES=4, BASE_DEPTH=3 (6 drain beats).
module tb_ifm_skew_rf_bank;

    localparam int DW = 8;
    localparam int LN = 4;
    localparam int BD = 3;
    localparam int SW = 5;
    localparam int NB = BD + LN - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic [SW-1:0]     size;
    logic              in_valid;
    logic              in_ready;
    logic [LN*DW-1:0]  data_in;
    logic              out_valid;
    logic              out_ready;
    logic [LN*DW-1:0]  data_out;
    logic              out_first;
    logic              out_last;
    logic [31:0]       stall_cnt;

    int errors = 0;
    int checks = 0;

    ifm_skew_rf_bank #(
        .DATA_WIDTH(DW), .LANES(LN), .BASE_DEPTH(BD), .SIZE_W(SW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .size(size),
        .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
        .out_first(out_first), .out_last(out_last), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Input word w of a tile: lane i carries 10*i + w + 1 + off.
    function automatic logic [LN*DW-1:0] tile_word(int w, int off);
        logic [LN*DW-1:0] v = '0;
        for (int i = 0; i < LN; i++) v[i*DW +: DW] = DW'(10*i + w + 1 + off);
        return v;
    endfunction

    // Expected drain beat k: lane i shows word k-i if in range and lane active.
    function automatic logic [LN*DW-1:0] exp_beat(int k, int sz, int off);
        logic [LN*DW-1:0] v = '0;
        int eff = (sz >= 1 && sz <= LN) ? sz : LN;
        for (int i = 0; i < LN; i++) begin
            int w = k - i;
            if (w >= 0 && w < BD && i < eff) v[i*DW +: DW] = DW'(10*i + w + 1 + off);
        end
        return v;
    endfunction

    task automatic load_tile(input string name, input int sz, input int off);
        for (int w = 0; w < BD; w++) begin
            int t = 0;
            size     = SW'(sz);
            data_in  = tile_word(w, off);
            in_valid = 1'b1;
            while (!in_ready && t < 50) begin
                @(posedge clk); #1;
                t++;
            end
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL %s load_timeout beat=%0d in_ready=%b required=1", name, w, in_ready);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        data_in  = '0;
    endtask

    task automatic drain_tile(input string name, input int sz, input int off,
                              input int stall_at, input int stall_len,
                              input int rdy_exp, input int n_beats);
        out_ready = 1'b1;
        for (int k = 0; k < n_beats; k++) begin
            logic [LN*DW-1:0] e = exp_beat(k, sz, off);
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("FAIL %s out_valid beat=%0d got=%b required=1", name, k, out_valid);
            end
            checks++;
            if (data_out !== e) begin
                errors++;
                $display("FAIL %s data_out beat=%0d got=%h required=%h", name, k, data_out, e);
            end
            checks++;
            if (out_first !== (k == 0) || out_last !== (k == NB - 1)) begin
                errors++;
                $display("FAIL %s first_last beat=%0d got=%b%b required=%b%b",
                         name, k, out_first, out_last, (k == 0), (k == NB - 1));
            end
            if (rdy_exp >= 0) begin
                checks++;
                if (in_ready !== rdy_exp[0]) begin
                    errors++;
                    $display("FAIL %s in_ready beat=%0d got=%b required=%0d", name, k, in_ready, rdy_exp);
                end
            end
            if (k == stall_at) begin
                out_ready = 1'b0;
                repeat (stall_len) begin
                    @(posedge clk); #1;
                    checks++;
                    if (out_valid !== 1'b1 || data_out !== e) begin
                        errors++;
                        $display("FAIL %s stall_hold beat=%0d got=%b/%h required=1/%h",
                                 name, k, out_valid, data_out, e);
                    end
                end
                out_ready = 1'b1;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || data_out !== '0 ||
            out_first !== 1'b0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL %s idle got v=%b r=%b d=%h f=%b l=%b required v=0 r=1 d=0 f=0 l=0",
                     name, out_valid, in_ready, data_out, out_first, out_last);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; size = '0; in_valid = 1'b0;
        data_in = '0; out_ready = 1'b1;
        #3;
        check_idle("reset");
        checks++;
        if (stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset stall_cnt got=%0d required=0", stall_cnt);
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_idle("post_reset");
    endtask

    task automatic test_basic();
        load_tile("basic", 4, 0);
        drain_tile("basic", 4, 0, -1, 0, -1, NB);
        check_idle("basic_done");
    endtask

    task automatic test_size();
        load_tile("size2", 2, 0);
        drain_tile("size2", 2, 0, -1, 0, -1, NB);
        load_tile("size0", 0, 0);
        drain_tile("size0", 0, 0, -1, 0, -1, NB);
        load_tile("size7", 7, 0);
        drain_tile("size7", 7, 0, -1, 0, -1, NB);
    endtask

    task automatic test_stall();
        int exp_stall;
`ifdef IFM_RF_STALL_CNT_EN
        exp_stall = 5;
`else
        exp_stall = 0;
`endif
        load_tile("stall", 4, 0);
        drain_tile("stall", 4, 0, 2, 5, -1, NB);
        checks++;
        if (stall_cnt !== 32'(exp_stall)) begin
            errors++;
            $display("FAIL stall stall_cnt got=%0d required=%0d", stall_cnt, exp_stall);
        end
        check_idle("stall_done");
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        load_tile("b2b_a", 4, 0);
        load_tile("b2b_b", 4, 100);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b both_full got r=%b v=%b required r=0 v=1", in_ready, out_valid);
        end
        drain_tile("b2b_a", 4, 0, -1, 0, 0, NB);
        drain_tile("b2b_b", 4, 100, -1, 0, 1, NB);
        check_idle("b2b_done");
    endtask

    task automatic test_flush();
        load_tile("flush", 4, 0);
        drain_tile("flush", 4, 0, -1, 0, -1, 2);
        flush = 1'b1; in_valid = 1'b1; data_in = '1; size = SW'(4);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; data_in = '0;
        check_idle("flush_cycle");
        checks++;
        if (stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL flush stall_cnt got=%0d required=0", stall_cnt);
        end
        load_tile("flush_fresh", 4, 50);
        drain_tile("flush_fresh", 4, 50, -1, 0, -1, NB);
        check_idle("flush_fresh_done");
    endtask

    task automatic test_async_reset();
        load_tile("arst", 3, 0);
        drain_tile("arst", 3, 0, -1, 0, -1, 2);
        rst_n = 1'b0;
        #1;
        check_idle("arst_low");
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_idle("arst_after");
        load_tile("arst_fresh", 4, 20);
        drain_tile("arst_fresh", 4, 20, -1, 0, -1, NB);
        check_idle("arst_fresh_done");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_size();
        test_stall();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
